// File: rtl/if_fetch_unit_pkg.sv
// ---- if_fetch_unit_pkg : redirect codes, bus widths and FIFO entry type (rev 1.0) ----
`default_nettype none

package if_fetch_unit_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic [INST_ADDR_BUS-1:0] RESET_PC_VAL = 32'hBFC0_0000;

  localparam logic [1:0] JT_SEQ = 2'b00;
  localparam logic [1:0] JT_JR  = 2'b01;
  localparam logic [1:0] JT_J   = 2'b10;
  localparam logic [1:0] JT_BR  = 2'b11;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0]      inst;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_BUS-1:0] seq_pc(input logic [INST_ADDR_BUS-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ---- ifetch_fifo : {pc, inst} circular buffer with keep-one selective flush (rev 1.0) ----
`default_nettype none

module ifetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [INST_ADDR_BUS-1:0] keep_pc,
  output logic                     keep_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] wr_base;
  logic [PW-1:0] keep_idx;
  logic [CW-1:0] cnt_base;

  // first live entry, ignoring the one being popped, whose pc matches keep_pc
  always_comb begin
    keep_hit = 1'b0;
    keep_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      if (!keep_hit && (i < int'(count)) && !(pop && (i == 0)) &&
          (mem[rd_ptr + PW'(i)].pc == keep_pc)) begin
        keep_hit = 1'b1;
        keep_idx = rd_ptr + PW'(i);
      end
    end
  end

  assign rd_next = rd_ptr + PW'(pop);

  always_comb begin
    if (flush) begin
      wr_base  = rd_next + PW'(keep_hit);
      cnt_base = CW'(keep_hit);
    end else begin
      wr_base  = wr_ptr;
      cnt_base = count - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_base + PW'(push);
      count  <= cnt_base + CW'(push);
    end
  end

  // storage carries no reset: the head is masked while count is zero
  always_ff @(posedge clk) begin
    if (flush && keep_hit) mem[rd_next] <= mem[keep_idx];
    if (push)              mem[wr_base] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ---- if_fetch_unit : fetch PC, single-outstanding imem requests, delay-slot aware redirects (rev 1.0) ----
`default_nettype none

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC   = RESET_PC_VAL,
  parameter int                       FIFO_DEPTH = 2
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst,
  input  logic                     stall,
  input  logic [1:0]               jtsel,
  input  logic [INST_ADDR_BUS-1:0] addr1,
  input  logic [INST_ADDR_BUS-1:0] addr2,
  input  logic [INST_ADDR_BUS-1:0] addr3,
  output logic                     imem_req,
  output logic [INST_ADDR_BUS-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [INST_BUS-1:0]      imem_rdata,
  output logic                     if_valid_o,
  output logic [INST_ADDR_BUS-1:0] if_pc_o,
  output logic [INST_BUS-1:0]      if_inst_o
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [INST_ADDR_BUS-1:0] fetch_pc;
  logic [INST_ADDR_BUS-1:0] fetch_pc_nxt;
  logic [INST_ADDR_BUS-1:0] issued_addr;
  logic [INST_ADDR_BUS-1:0] redir_pc;
  logic [INST_ADDR_BUS-1:0] target;
  logic [INST_ADDR_BUS-1:0] dslot_pc;
  logic                     outstanding;
  logic                     discard;
  logic                     redir_pend;
  logic [CW-1:0]            fifo_count;
  fetch_entry_t             head;
  fetch_entry_t             push_data;
  logic                     fire, grant, resp, push, redirect;
  logic                     keep_hit, d_held, case1, case2;

  assign fire     = if_valid_o & ~stall;
  assign redirect = fire & (jtsel != JT_SEQ);
  assign dslot_pc = seq_pc(if_pc_o);

  always_comb begin
    case (jtsel)
      JT_JR:   target = addr3;
      JT_BR:   target = addr2;
      default: target = addr1;
    endcase
  end

  // issue only when the returning word is guaranteed a FIFO slot
  assign imem_req  = ~cpu_rst & ~outstanding & (fifo_count < DEPTH_C);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;
  assign resp      = imem_rvalid & outstanding;

  assign d_held = keep_hit | (outstanding & ~discard & (issued_addr == dslot_pc));
  assign case2  = redirect & ~d_held & (fetch_pc == dslot_pc);
  assign case1  = redirect & ~case2;

  assign push      = resp & ~discard & ~(case1 & (issued_addr != dslot_pc));
  assign push_data = '{pc: issued_addr, inst: imem_rdata};

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (grant)                      fetch_pc_nxt = redir_pend ? redir_pc : seq_pc(fetch_pc);
    if (case1 || (case2 && grant))  fetch_pc_nxt = target;
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      fetch_pc    <= RESET_PC;
      issued_addr <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      redir_pend  <= 1'b0;
      redir_pc    <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      if (grant) begin
        outstanding <= 1'b1;
        issued_addr <= fetch_pc;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      // a freshly granted non-delay-slot fetch under a redirect is stale at birth
      if (grant)                                                discard <= case1 & (fetch_pc != dslot_pc);
      else if (resp)                                            discard <= 1'b0;
      else if (case1 && outstanding && issued_addr != dslot_pc) discard <= 1'b1;
      if (grant) begin
        redir_pend <= 1'b0;
      end else if (case2) begin
        redir_pend <= 1'b1;
        redir_pc   <= target;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (cpu_clk_50M),
    .rst        (cpu_rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (fire),
    .flush      (case1),
    .keep_pc    (dslot_pc),
    .keep_hit   (keep_hit),
    .count      (fifo_count),
    .head_valid (if_valid_o),
    .head       (head)
  );

  assign if_pc_o   = head.pc;
  assign if_inst_o = head.inst;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ---- tb_if_fetch_unit : randomized fetch front-end bench with a program-order scoreboard (rev 1.0) ----
`default_nettype none

module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b1;
  logic [1:0]  jtsel = 2'b00;
  logic [31:0] addr1 = '0, addr2 = '0, addr3 = '0;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_inst;

  if_fetch_unit dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .stall       (stall),
    .jtsel       (jtsel),
    .addr1       (addr1),
    .addr2       (addr2),
    .addr3       (addr3),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (gnt),
    .imem_rvalid (rvalid),
    .imem_rdata  (rdata),
    .if_valid_o  (if_valid),
    .if_pc_o     (if_pc),
    .if_inst_o   (if_inst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fires = 0;

  int gnt_pct = 100, lat_max = 1, stall_pct = 0, redir_pct = 0;
  bit force_stall = 1'b1;

  logic [31:0] exp_q[$];
  logic [31:0] grant_log[$];
  logic [31:0] model_pc = RST_PC;
  logic [31:0] model_tgt = '0;
  logic [31:0] tgt;
  bit          in_dslot = 1'b0;

  bit          resp_busy = 1'b0, resp_gprev = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_qa = '0, resp_ga = '0;

  // memory contents: a fixed scramble of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_fires(input int n, input int budget);
    int goal;
    int c;
    goal = fires + n;
    c = 0;
    while (fires < goal && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("fire_budget", 32'(fires >= goal), 32'd1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc = RST_PC;
    in_dslot = 1'b0;
  endtask

  // instruction memory: random grant, 1..lat_max cycle response, one request at a time
  initial begin : responder
    forever begin
      @(negedge clk);
      rvalid = 1'b0;
      if (resp_gprev) begin
        resp_busy = 1'b1;
        resp_cnt  = $urandom_range(1, lat_max);
        resp_qa   = resp_ga;
      end
      if (resp_busy) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          rvalid    = 1'b1;
          rdata     = mem_word(resp_qa);
          resp_busy = 1'b0;
        end
      end
      resp_gprev = 1'b0;
      gnt = 1'b0;
      if (imem_req && !resp_busy && ($urandom_range(1, 100) <= gnt_pct)) begin
        gnt        = 1'b1;
        resp_gprev = 1'b1;
        resp_ga    = imem_addr;
        grant_log.push_back(imem_addr);
      end
    end
  end

  // decode stand-in: decides stall and redirects, and records the architectural PC order
  initial begin : driver
    forever begin
      @(negedge clk);
      stall = force_stall || ($urandom_range(1, 100) <= stall_pct);
      jtsel = 2'($urandom_range(0, 3));
      addr1 = $urandom;
      addr2 = $urandom;
      addr3 = $urandom;
      if (!rst && if_valid && !stall) begin
        exp_q.push_back(model_pc);
        jtsel = 2'b00;
        if (in_dslot) begin
          model_pc = model_tgt;
          in_dslot = 1'b0;
        end else if ($urandom_range(1, 100) <= redir_pct) begin
          jtsel = 2'($urandom_range(1, 3));
          tgt   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
          case (jtsel)
            2'b01:   addr3 = tgt;
            2'b10:   addr1 = tgt;
            default: addr2 = tgt;
          endcase
          model_tgt = tgt;
          in_dslot  = 1'b1;
          model_pc  = model_pc + 32'd4;
        end else begin
          model_pc = model_pc + 32'd4;
        end
        fires++;
      end
    end
  end

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fire_unexpected: got pc %h expected no delivery", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("fire_pc", if_pc, e);
          check("fire_inst", if_inst, mem_word(e));
        end
      end
    end
  end

  initial begin : main
    int cyc;
    int w;
    cycles(3);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_inst", if_inst, 32'd0);

    model_reset();
    grant_log.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!if_valid && cyc < 20);
    check("first_valid_cycle", 32'(cyc), 32'd2);

    cycles(10);
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_grants", 32'(grant_log.size()), 32'd2);
    check("stall_head_pc", if_pc, RST_PC);
    check("stall_head_inst", if_inst, mem_word(RST_PC));
    check("grant0", grant_log[0], RST_PC);
    check("grant1", grant_log[1], RST_PC + 32'd4);
    force_stall = 1'b0;
    wait_fires(3, 100);
    check("grant2", grant_log[2], RST_PC + 32'd8);

    gnt_pct = 75; lat_max = 5; stall_pct = 25; redir_pct = 30;
    wait_fires(400, 20000);

    // reset while a request is in flight; its late response must be ignored
    gnt_pct = 100; redir_pct = 0; stall_pct = 0;
    w = 0;
    while (!(resp_busy && resp_cnt >= 2) && w < 200) begin
      cycles(1);
      w++;
    end
    check("inflight_found", 32'(resp_busy && resp_cnt >= 2), 32'd1);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_valid", 32'(if_valid), 32'd0);
    wait_fires(20, 400);

    gnt_pct = 70; stall_pct = 20; redir_pct = 40;
    wait_fires(150, 8000);

    force_stall = 1'b1;
    @(negedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
